tmr_vote_scrub: RTL and testbench

TMR_VOTE_SCRUB -- requirements
Module: tmr_vote_scrub

---
 rtl/tmr_vote_pkg.sv | 11 +
 rtl/tmr_majority.sv | 23 ++
 rtl/tmr_vote_scrub.sv | 119 +++++++++++
 tb/tb_tmr_vote_scrub.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/tmr_vote_pkg.sv
// Shared types and constants for the TMR voter/scrubber.
package tmr_vote_pkg;

  localparam int unsigned ERR_CNT_W = 8;

  typedef enum logic [0:0] {
    IDLE,
    SCRUB
  } tmr_state_e;

endpackage

// File: rtl/tmr_majority.sv
// Combinational bitwise 2-of-3 voter with per-copy mismatch mask and
// no-majority detection.
module tmr_majority #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  output logic [WIDTH-1:0] maj_o,
  output logic [2:0]       mism_o,
  output logic             multi_o
);

  always_comb begin
    maj_o     = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    mism_o[0] = (a_i != maj_o);
    mism_o[1] = (b_i != maj_o);
    mism_o[2] = (c_i != maj_o);
    // Whole-word agreement of any pair means the word has a true majority.
    multi_o   = (a_i != b_i) && (a_i != c_i) && (b_i != c_i);
  end

endmodule

// File: rtl/tmr_vote_scrub.sv
// TMR voter with write-back scrub handshake and optional saturating error
// counter (enabled by macro TMR_ERR_CNT_EN).
module tmr_vote_scrub
  import tmr_vote_pkg::*;
#(
  parameter int unsigned     WIDTH = 4,
  parameter logic [WIDTH-1:0] INIT = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     data_a,
  input  logic [WIDTH-1:0]     data_b,
  input  logic [WIDTH-1:0]     data_c,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out,
  output logic                 out_valid,
  output logic [2:0]           err_lane,
  output logic                 multi_err,
  output logic                 fix_req,
  output logic [WIDTH-1:0]     fix_data,
  output logic [2:0]           fix_lane,
  input  logic                 fix_ack,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic [WIDTH-1:0] maj;
  logic [2:0]       mism;
  logic             multi;
  logic             accept;
  logic             scrub_start;

  tmr_state_e state_q, state_d;

  logic [WIDTH-1:0] out_q, fix_data_q;
  logic [2:0]       err_lane_q, fix_lane_q;
  logic             out_valid_q, multi_err_q;

  tmr_majority #(
    .WIDTH (WIDTH)
  ) u_majority (
    .a_i     (data_a),
    .b_i     (data_b),
    .c_i     (data_c),
    .maj_o   (maj),
    .mism_o  (mism),
    .multi_o (multi)
  );

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    scrub_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && (|mism) && !multi) begin
          state_d     = SCRUB;
          scrub_start = 1'b1;
        end
      end
      SCRUB: begin
        if (fix_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_q       <= INIT;
      fix_data_q  <= INIT;
      out_valid_q <= 1'b0;
      err_lane_q  <= '0;
      multi_err_q <= 1'b0;
      fix_lane_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= accept;
      if (accept) begin
        out_q       <= maj;
        err_lane_q  <= mism;
        multi_err_q <= multi;
      end
      // Write-back target is latched once and held for the whole handshake.
      if (scrub_start) begin
        fix_data_q <= maj;
        fix_lane_q <= mism;
      end
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign err_lane  = err_lane_q;
  assign multi_err = multi_err_q;
  assign fix_req   = (state_q == SCRUB);
  assign fix_data  = fix_data_q;
  assign fix_lane  = fix_lane_q;

`ifdef TMR_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (accept && (|mism) && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_tmr_vote_scrub.sv
// Scoreboard bench for tmr_vote_scrub: directed vectors push expected results,
// a negedge monitor pops them whenever out_valid is seen.
module tb_tmr_vote_scrub;

  localparam logic [3:0] INIT_V = 4'h5;

  typedef struct packed {
    logic [3:0] out;
    logic [2:0] lane;
    logic       multi;
    logic       fix;
    logic [7:0] cnt;
  } exp_t;

  typedef struct packed {
    logic [3:0] a, b, c, out;
    logic [2:0] lane;
    logic       multi;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] data_a = '0, data_b = '0, data_c = '0;
  logic       in_valid = 1'b0;
  logic       fix_ack = 1'b0;
  logic       in_ready, out_valid, multi_err, fix_req;
  logic [3:0] out, fix_data;
  logic [2:0] err_lane, fix_lane;
  logic [7:0] err_cnt;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   sw_cnt = 0;
  exp_t exp_q[$];
  vec_t vecs[7];

  tmr_vote_scrub #(
    .WIDTH (4),
    .INIT  (INIT_V)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_a    (data_a),
    .data_b    (data_b),
    .data_c    (data_c),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .err_lane  (err_lane),
    .multi_err (multi_err),
    .fix_req   (fix_req),
    .fix_data  (fix_data),
    .fix_lane  (fix_lane),
    .fix_ack   (fix_ack),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every out_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 32'(out_valid), 32'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out", 32'(out), 32'(e.out));
        chk("err_lane", 32'(err_lane), 32'(e.lane));
        chk("multi_err", 32'(multi_err), 32'(e.multi));
        chk("fix_req_at_out", 32'(fix_req), 32'(e.fix));
        chk("err_cnt", 32'(err_cnt), 32'(e.cnt));
        if (e.fix) begin
          chk("fix_data", 32'(fix_data), 32'(e.out));
          chk("fix_lane", 32'(fix_lane), 32'(e.lane));
        end
      end
    end
  end

  task automatic wait_ready();
    int k;
    k = 0;
    while (!in_ready && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'(1));
  endtask

  // Issue one word; for scrub-triggering words optionally run the ack handshake
  // after hold_cyc cycles, offering a blocked word meanwhile.
  task automatic send(input vec_t v, input bit do_ack, input int hold_cyc);
    logic fix;
    wait_ready();
    fix = (v.lane != 3'b000) && !v.multi;
`ifdef TMR_ERR_CNT_EN
    if (v.lane != 3'b000 && sw_cnt < 255) sw_cnt++;
`endif
    exp_q.push_back('{out: v.out, lane: v.lane, multi: v.multi, fix: fix, cnt: 8'(sw_cnt)});
    data_a   = v.a;
    data_b   = v.b;
    data_c   = v.c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (fix) begin
      chk("in_ready_scrub", 32'(in_ready), 32'(0));
      if (do_ack) begin
        for (int i = 0; i < hold_cyc; i++) begin
          data_a   = 4'h7;
          data_b   = 4'h7;
          data_c   = 4'h7;
          in_valid = 1'b1;
          @(posedge clk);
          #1;
          chk("fix_req_hold", 32'(fix_req), 32'(1));
          chk("fix_data_hold", 32'(fix_data), 32'(v.out));
        end
        in_valid = 1'b0;
        fix_ack  = 1'b1;
        @(posedge clk);
        #1;
        fix_ack = 1'b0;
        chk("fix_req_after_ack", 32'(fix_req), 32'(0));
        chk("in_ready_after_ack", 32'(in_ready), 32'(1));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{a: 4'hA, b: 4'hA, c: 4'hA, out: 4'hA, lane: 3'b000, multi: 1'b0};
    vecs[1] = '{a: 4'hA, b: 4'hA, c: 4'h2, out: 4'hA, lane: 3'b100, multi: 1'b0};
    vecs[2] = '{a: 4'h1, b: 4'h2, c: 4'h4, out: 4'h0, lane: 3'b111, multi: 1'b1};
    vecs[3] = '{a: 4'h3, b: 4'h5, c: 4'h3, out: 4'h3, lane: 3'b010, multi: 1'b0};
    vecs[4] = '{a: 4'h0, b: 4'hF, c: 4'hF, out: 4'hF, lane: 3'b001, multi: 1'b0};
    vecs[5] = '{a: 4'h6, b: 4'h9, c: 4'hF, out: 4'hF, lane: 3'b011, multi: 1'b1};
    vecs[6] = '{a: 4'hC, b: 4'hC, c: 4'hC, out: 4'hC, lane: 3'b000, multi: 1'b0};

    // Reset held two cycles.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out", 32'(out), 32'(INIT_V));
    chk("rst_fix_data", 32'(fix_data), 32'(INIT_V));
    chk("rst_fix_req", 32'(fix_req), 32'(0));
    chk("rst_err_cnt", 32'(err_cnt), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_err_lane", 32'(err_lane), 32'(0));
    chk("rst_multi", 32'(multi_err), 32'(0));
    chk("rst_fix_lane", 32'(fix_lane), 32'(0));

    // Clean word, then confirm nothing moves without a transfer.
    send(vecs[0], 1'b1, 0);
    chk("clean_in_ready", 32'(in_ready), 32'(1));
    data_a = 4'h3;
    data_b = 4'h3;
    data_c = 4'h3;
    fix_ack = 1'b1;  // must be ignored in IDLE
    repeat (3) @(posedge clk);
    #1;
    fix_ack = 1'b0;
    chk("idle_out_stable", 32'(out), 32'(4'hA));
    chk("idle_ack_ignored", 32'(fix_req), 32'(0));

    // Single upset with a 3-cycle ack delay, then the remaining patterns.
    for (int i = 1; i < 7; i++) send(vecs[i], 1'b1, 3);
    repeat (2) @(posedge clk);
    #1;
    chk("multi_no_scrub", 32'(fix_req), 32'(0));

    // Reset mid-SCRUB: no ack given.
    send(vecs[1], 1'b0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sw_cnt = 0;
    chk("abort_fix_req", 32'(fix_req), 32'(0));
    chk("abort_in_ready", 32'(in_ready), 32'(1));
    chk("abort_err_cnt", 32'(err_cnt), 32'(0));
    chk("abort_out", 32'(out), 32'(INIT_V));

    // Reset wins over a simultaneous transfer and ack.
    data_a   = 4'h9;
    data_b   = 4'h9;
    data_c   = 4'h1;
    in_valid = 1'b1;
    fix_ack  = 1'b1;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    fix_ack  = 1'b0;
    chk("rst_prio_valid", 32'(out_valid), 32'(0));
    chk("rst_prio_out", 32'(out), 32'(INIT_V));
    chk("rst_prio_fix_req", 32'(fix_req), 32'(0));

    // Saturation run: 260 acked single-upset words.
    for (int i = 0; i < 260; i++) send(vecs[1], 1'b1, 0);
    repeat (2) @(posedge clk);
    #1;
`ifdef TMR_ERR_CNT_EN
    chk("sat_err_cnt", 32'(err_cnt), 32'(255));
`else
    chk("sat_err_cnt", 32'(err_cnt), 32'(0));
`endif
    chk("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
